// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU: ADD/SUB/AND/OR/XOR/SLT with registered result and NZCV flags.
// Define ALU_MUL_EN to add an iterative unsigned shift-add multiply on op 110.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             busy
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam int unsigned CW    = $clog2(WIDTH);
`endif

    logic             accept;
    logic             sub;
    logic             slt;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] res1;
    logic             c1;
    logic             v1;
    logic [3:0]       flg1;

    assign accept = in_valid && in_ready;

    // Single-cycle datapath; reserved ops fall through to result 0, flags 0100.
    always_comb begin
        sub  = (op == OP_SUB);
        slt  = ($signed(a) < $signed(b));
        sum  = {1'b0, a} + {1'b0, (sub ? ~b : b)} + {{WIDTH{1'b0}}, sub};
        res1 = '0;
        c1   = 1'b0;
        v1   = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                res1 = sum[WIDTH-1:0];
                c1   = sum[WIDTH];
                v1   = ~(a[WIDTH-1] ^ b[WIDTH-1] ^ sub) & (a[WIDTH-1] ^ sum[WIDTH-1]);
            end
            OP_AND:  res1 = a & b;
            OP_OR:   res1 = a | b;
            OP_XOR:  res1 = a ^ b;
            OP_SLT:  res1 = {{(WIDTH-1){1'b0}}, slt};
            default: res1 = '0;
        endcase
        flg1 = {res1[WIDTH-1], (res1 == '0), c1, v1};
    end

`ifdef ALU_MUL_EN
    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     step_sum;
    logic [2*WIDTH-1:0] acc_next;

    // Upper half accumulates the multiplicand while the multiplier shifts out of the lower half.
    always_comb begin
        step_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        acc_next = {step_sum, acc[WIDTH-1:1]};
    end

    assign in_ready = (state == S_IDLE) && (!out_valid || out_ready);
    assign busy     = (state == S_MUL);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
            mcand     <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (op == OP_MUL) begin
                            state <= S_MUL;
                            mcand <= a;
                            acc   <= {{WIDTH{1'b0}}, b};
                            cnt   <= '0;
                        end else begin
                            out_valid <= 1'b1;
                            result    <= res1;
                            flags     <= flg1;
                        end
                    end
                end
                S_MUL: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b1;
                        result    <= acc_next[WIDTH-1:0];
                        flags     <= {acc_next[WIDTH-1], (acc_next[WIDTH-1:0] == '0),
                                      1'b0, (acc_next[2*WIDTH-1:WIDTH] != '0)};
                    end
                end
            endcase
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign busy     = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept) begin
                out_valid <= 1'b1;
                result    <= res1;
                flags     <= flg1;
            end
        end
    end
`endif

endmodule
